median5_stream: RTL
===================

MEDIAN5_STREAM -- requirements
Module: median5_stream

Interface
REQ-001 Parameter: WIDTH, default 8, sample width in bits; all samples are treated as unsigned.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: in_valid  input  1  in_data holds a valid sample.
REQ-005 Port: in_data  input  WIDTH  sample value.
REQ-006 Port: in_ready  output  1  block can accept a sample.
REQ-007 Port: out_valid  output  1  result outputs are valid.
REQ-008 Port: out_ready  input  1  consumer accepts the result.
REQ-009 Port: out_median  output  WIDTH  median of the 5-sample window.
REQ-010 Port: out_min  output  WIDTH  minimum of the window.
REQ-011 Port: out_max  output  WIDTH  maximum of the window.

Function
REQ-012 A sample SHALL be accepted on any clock edge where in_valid and in_ready are both 1.
REQ-013 The window SHALL be a 5-entry shift register; each accepted sample enters entry 0 and the oldest entry is discarded.
REQ-014 The fill counter SHALL saturate at 5.
REQ-015 The FSM SHALL have exactly three states: IDLE, SORT and OUT.
REQ-016 in_ready SHALL equal 1 only in IDLE while rst is 0.
REQ-017 In IDLE, an accept that leaves fill below 5 SHALL keep the FSM in IDLE and produce no output.
REQ-018 In IDLE, an accept that makes fill equal 5 (or with fill already 5) SHALL copy the updated window into the sort array, clear the phase counter and enter SORT.
REQ-019 SORT SHALL perform one odd-even transposition phase per cycle: even phases compare-swap pairs (0,1),(2,3); odd phases compare-swap pairs (1,2),(3,4).
REQ-020 SORT SHALL last exactly 5 cycles (phases 0..4) and then enter OUT.
REQ-021 The sort array SHALL be ascending after phase 4; out_min = entry 0, out_median = entry 2, out_max = entry 4.
REQ-022 The first sort phase SHALL occur on the first edge after the accepting edge; out_valid SHALL rise 6 edges after the accepting edge.
REQ-023 In OUT, out_valid SHALL be 1 and all result outputs SHALL be held stable until out_ready is 1.
REQ-024 The edge in OUT with out_ready = 1 SHALL return the FSM to IDLE, and out_valid SHALL be 0 on the following cycle.
REQ-025 in_valid SHALL be ignored in SORT and OUT, and the window SHALL not change in those states.
REQ-026 Compare-swap of equal values SHALL not swap, so duplicates yield the correct median.
REQ-027 Result outputs SHALL retain their last values while out_valid is 0.

Reset
REQ-028 When rst is 1 at a clock edge, the following SHALL be cleared:
- state to IDLE;
- fill, phase counter, window and sort array to 0;
- out_valid, out_median, out_min and out_max to 0.
REQ-029 Reset asserted during SORT or OUT SHALL abort the operation, discard the pending result, and require 5 new samples before the next output.
REQ-030 in_ready SHALL be 0 during any cycle in which rst is 1.

Structure
REQ-031 A shared package median_pkg SHALL hold the following:
- the state enumeration (IDLE, SORT, OUT);
- constant WIN_LEN = 5;
- constant SORT_PHASES = 5;
- the phase-counter width.
REQ-032 The compare-swap pair SHALL be one sub-module, cmp_swap (inputs a, b; outputs lo, hi; WIDTH parameter), instantiated once per pair position.
REQ-033 The window and sort array SHALL be registers, with no combinational path from in_data to any output.

Verification
REQ-034 Reset, then accept samples 10,50,30,20,40 -> out_valid 6 edges after the 5th accept, with median 30, min 10, max 50; no out_valid earlier.
REQ-035 After REQ-034, accept 5 -> window {5,40,20,30,50} -> median 30, min 5, max 50.
REQ-036 Samples 7,7,7,200,0 -> median 7, min 0, max 200; samples 255,255,0,0,128 -> median 128, min 0, max 255.
REQ-037 Hold out_ready at 0 for 10 cycles in OUT while driving in_valid = 1 -> outputs stable, in_ready = 0, window unchanged; release -> IDLE on the next edge.
REQ-038 Assert rst for 1 cycle at SORT phase 2 -> all outputs 0 and IDLE; the next 4 accepts produce no output, and the 5th produces a correct result.

Source files
------------

// File: rtl/median_pkg.sv
// Shared definitions for the 5-sample streaming median/min/max block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package median_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int WIN_LEN     = 5;
    localparam int SORT_PHASES = 5;
    // Counter covers phases 0..4 plus the terminal value 5 used for the
    // result-latch cycle.
    localparam int PH_W        = $clog2(SORT_PHASES + 1);

endpackage

// File: rtl/cmp_swap.sv
// Compare-swap element: routes the smaller operand to lo and the larger to hi.
// Latency: combinational.
// Backpressure: n/a; equal operands pass through unswapped.
module cmp_swap #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic swap;

    // Strict compare so that ties keep their original order.
    assign swap = (b < a);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/median5_stream.sv
// Streaming 5-sample window; emits median/min/max once the window is full.
// Latency: out_valid rises 6 edges after the accepting edge (5 sort phases + result latch).
// Backpressure: in_ready only in IDLE; result held in OUT until out_ready.
module median5_stream
    import median_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_median,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max
);

    localparam int FILL_W = $clog2(WIN_LEN + 1);

    state_t            state, state_nxt;
    logic [FILL_W-1:0] fill, fill_inc;
    logic [PH_W-1:0]   phase;
    logic [WIDTH-1:0]  win     [WIN_LEN];
    logic [WIDTH-1:0]  win_sh  [WIN_LEN];
    logic [WIDTH-1:0]  arr     [WIN_LEN];
    logic [WIDTH-1:0]  arr_nxt [WIN_LEN];
    logic [WIDTH-1:0]  e01_lo, e01_hi, e23_lo, e23_hi;
    logic [WIDTH-1:0]  o12_lo, o12_hi, o34_lo, o34_hi;
    logic              accept, full_nxt, sort_done;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == OUT);
    assign accept    = in_valid && in_ready;
    assign fill_inc  = (fill == FILL_W'(WIN_LEN)) ? fill : fill + 1'b1;
    assign full_nxt  = (fill_inc == FILL_W'(WIN_LEN));
    assign sort_done = (phase == PH_W'(SORT_PHASES));

    // Even-phase pairs (0,1),(2,3) and odd-phase pairs (1,2),(3,4).
    cmp_swap #(.WIDTH(WIDTH)) u_e01 (.a(arr[0]), .b(arr[1]), .lo(e01_lo), .hi(e01_hi));
    cmp_swap #(.WIDTH(WIDTH)) u_e23 (.a(arr[2]), .b(arr[3]), .lo(e23_lo), .hi(e23_hi));
    cmp_swap #(.WIDTH(WIDTH)) u_o12 (.a(arr[1]), .b(arr[2]), .lo(o12_lo), .hi(o12_hi));
    cmp_swap #(.WIDTH(WIDTH)) u_o34 (.a(arr[3]), .b(arr[4]), .lo(o34_lo), .hi(o34_hi));

    // Window after shifting in the current sample at entry 0.
    always_comb begin
        win_sh[0] = in_data;
        for (int i = 1; i < WIN_LEN; i++) begin
            win_sh[i] = win[i-1];
        end
    end

    // One odd-even transposition phase, selected by the phase parity.
    always_comb begin
        arr_nxt = arr;
        if (!phase[0]) begin
            arr_nxt[0] = e01_lo;
            arr_nxt[1] = e01_hi;
            arr_nxt[2] = e23_lo;
            arr_nxt[3] = e23_hi;
        end else begin
            arr_nxt[1] = o12_lo;
            arr_nxt[2] = o12_hi;
            arr_nxt[3] = o34_lo;
            arr_nxt[4] = o34_hi;
        end
    end

    // Next-state logic for the IDLE/SORT/OUT controller.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && full_nxt) state_nxt = SORT;
            SORT:    if (sort_done)          state_nxt = OUT;
            OUT:     if (out_ready)          state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // State register plus window, sort array and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fill       <= '0;
            phase      <= '0;
            out_median <= '0;
            out_min    <= '0;
            out_max    <= '0;
            for (int i = 0; i < WIN_LEN; i++) begin
                win[i] <= '0;
                arr[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        win  <= win_sh;
                        fill <= fill_inc;
                        if (full_nxt) begin
                            arr   <= win_sh;
                            phase <= '0;
                        end
                    end
                end
                SORT: begin
                    if (!sort_done) begin
                        arr   <= arr_nxt;
                        phase <= phase + 1'b1;
                    end else begin
                        // Array is fully ordered; latch results as OUT is entered.
                        out_min    <= arr[0];
                        out_median <= arr[2];
                        out_max    <= arr[4];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
